// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline hazard controller.
// Tuse/Tnew codes count cycles until a value is needed / forwardable.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned T_W         = 2;
  localparam int unsigned STALL_CNT_W = 32;

  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;

  localparam logic [T_W-1:0] T0 = 2'd0;
  localparam logic [T_W-1:0] T1 = 2'd1;
  localparam logic [T_W-1:0] T2 = 2'd2;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // A source hits a producer when it reads a live register the producer writes
  // and needs it before the producer can forward it.
  function automatic logic haz_hit(input logic             use_src,
                                   input logic [REG_W-1:0] src,
                                   input logic [T_W-1:0]   tuse,
                                   input logic [REG_W-1:0] dst,
                                   input logic [T_W-1:0]   tnew);
    return use_src && (src != '0) && (dst == src) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side view of the hazard controller: ID sources, EX/MEM producers,
// MD unit start, flush, and the resulting stall/busy indications.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [REG_W-1:0]       IDRs;
  logic [REG_W-1:0]       IDRt;
  logic                   IDUseRs;
  logic                   IDUseRt;
  logic [T_W-1:0]         IDTuseRs;
  logic [T_W-1:0]         IDTuseRt;
  logic                   IDMdOp;
  logic [REG_W-1:0]       EXRegDst;
  logic [REG_W-1:0]       MEMRegDst;
  logic [T_W-1:0]         EXTnew;
  logic [T_W-1:0]         MEMTnew;
  logic                   EXMdStart;
  logic                   EXMdIsDiv;
  logic                   ExcFlush;
  logic                   Stall;
  logic                   MdBusy;
  logic                   MdDone;
  logic [STALL_CNT_W-1:0] StallCnt;

  modport master (
    output IDRs, IDRt, IDUseRs, IDUseRt, IDTuseRs, IDTuseRt, IDMdOp,
    output EXRegDst, MEMRegDst, EXTnew, MEMTnew, EXMdStart, EXMdIsDiv, ExcFlush,
    input  Stall, MdBusy, MdDone, StallCnt
  );

  modport slave (
    input  IDRs, IDRt, IDUseRs, IDUseRt, IDTuseRs, IDTuseRt, IDMdOp,
    input  EXRegDst, MEMRegDst, EXTnew, MEMTnew, EXMdStart, EXMdIsDiv, ExcFlush,
    output Stall, MdBusy, MdDone, StallCnt
  );

endinterface

// File: rtl/hazard_ctrl_md_seq.sv
// Multiply/divide occupancy sequencer: loads a cycle count on start and
// counts down, flagging busy and a done pulse on the final busy cycle.
module md_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
  parameter int unsigned CNT_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start,
  input  logic md_is_div,
  input  logic flush,
  output logic md_busy,
  output logic md_done
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] load_val;
  logic             start_ok;

  assign start_ok = md_start && !flush;
  assign load_val = md_is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      md_busy <= 1'b0;
      md_done <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_busy <= (state_d == MD_BUSY);
      md_done <= (state_d == MD_BUSY) && (cnt_d == CNT_W'(1));
    end
  end

  // A start while busy is illegal but still reloads, so a bad program degrades predictably.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start_ok) begin
          state_d = MD_BUSY;
          cnt_d   = load_val;
        end
      end
      MD_BUSY: begin
        if (start_ok) begin
          cnt_d = load_val;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (!rst_n) !((state_q == MD_BUSY) && md_start)
  );

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls ID on unforwardable RAW hazards and on
// HI/LO access while the MD unit is occupied, and counts stall cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
  parameter int unsigned CNT_W    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hif
);

  logic                   haz_rs_ex, haz_rt_ex, haz_rs_mem, haz_rt_mem;
  logic                   haz_md;
  logic                   stall_c;
  logic                   md_busy, md_done;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  assign haz_rs_ex  = haz_hit(hif.IDUseRs, hif.IDRs, hif.IDTuseRs, hif.EXRegDst,  hif.EXTnew);
  assign haz_rt_ex  = haz_hit(hif.IDUseRt, hif.IDRt, hif.IDTuseRt, hif.EXRegDst,  hif.EXTnew);
  assign haz_rs_mem = haz_hit(hif.IDUseRs, hif.IDRs, hif.IDTuseRs, hif.MEMRegDst, hif.MEMTnew);
  assign haz_rt_mem = haz_hit(hif.IDUseRt, hif.IDRt, hif.IDTuseRt, hif.MEMRegDst, hif.MEMTnew);

  // The op being started in EX already occupies the unit from ID's point of view.
  assign haz_md  = hif.IDMdOp && (md_busy || hif.EXMdStart);
  assign stall_c = (haz_rs_ex || haz_rt_ex || haz_rs_mem || haz_rt_mem || haz_md)
                   && !hif.ExcFlush;

  md_seq #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .md_start  (hif.EXMdStart),
    .md_is_div (hif.EXMdIsDiv),
    .flush     (hif.ExcFlush),
    .md_busy   (md_busy),
    .md_done   (md_done)
  );

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign hif.Stall    = stall_c;
  assign hif.MdBusy   = md_busy;
  assign hif.MdDone   = md_done;
  assign hif.StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a queue-based expected-value scoreboard.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif)
  );

  typedef struct {
    string       tag;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic st, input logic bz, input logic dn);
    exp_t e;
    e.tag = tag; e.stall = st; e.busy = bz; e.done = dn; e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      cmp({e.tag, "_stall"},    {31'd0, hif.Stall},  {31'd0, e.stall});
      cmp({e.tag, "_busy"},     {31'd0, hif.MdBusy}, {31'd0, e.busy});
      cmp({e.tag, "_done"},     {31'd0, hif.MdDone}, {31'd0, e.done});
      cmp({e.tag, "_stallcnt"}, hif.StallCnt,        e.cnt);
    end
  endtask

  // One pipeline cycle: inputs already driven, check mid-cycle, advance past the edge.
  task automatic step(input string tag, input logic st, input logic bz, input logic dn);
    push(tag, st, bz, dn);
    @(negedge clk);
    pop_check();
    if (st && rst_n) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hif.IDRs = '0; hif.IDRt = '0; hif.IDUseRs = 1'b0; hif.IDUseRt = 1'b0;
    hif.IDTuseRs = T0; hif.IDTuseRt = T0; hif.IDMdOp = 1'b0;
    hif.EXRegDst = '0; hif.MEMRegDst = '0; hif.EXTnew = T0; hif.MEMTnew = T0;
    hif.EXMdStart = 1'b0; hif.EXMdIsDiv = 1'b0; hif.ExcFlush = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    exp_cnt = 32'd0;
    step("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    do_reset();

    // Load-use: lw $8 in EX, add reads $8 in EX stage.
    hif.IDRs = 5'd8; hif.IDUseRs = 1'b1; hif.IDTuseRs = T1;
    hif.EXRegDst = 5'd8; hif.EXTnew = T2;
    step("loaduse_ex", 1'b1, 1'b0, 1'b0);
    hif.EXRegDst = '0; hif.EXTnew = T0;
    hif.MEMRegDst = 5'd8; hif.MEMTnew = T1;
    step("loaduse_mem", 1'b0, 1'b0, 1'b0);

    // Same match but the source is not read.
    idle();
    hif.IDRs = 5'd8; hif.IDUseRs = 1'b0; hif.EXRegDst = 5'd8; hif.EXTnew = T2;
    step("nouse", 1'b0, 1'b0, 1'b0);

    // Branch after ALU op on Rt.
    idle();
    hif.IDRt = 5'd9; hif.IDUseRt = 1'b1; hif.IDTuseRt = T0;
    hif.EXRegDst = 5'd9; hif.EXTnew = T1;
    step("branch_ex", 1'b1, 1'b0, 1'b0);
    hif.EXRegDst = '0; hif.EXTnew = T0;
    hif.MEMRegDst = 5'd9; hif.MEMTnew = T0;
    step("branch_mem0", 1'b0, 1'b0, 1'b0);
    hif.MEMTnew = T1;
    step("branch_mem1", 1'b1, 1'b0, 1'b0);

    // Register $0 never stalls.
    idle();
    hif.IDRs = '0; hif.IDUseRs = 1'b1; hif.IDTuseRs = T0;
    hif.EXRegDst = '0; hif.EXTnew = T2;
    step("reg0", 1'b0, 1'b0, 1'b0);

    // Flush overrides a data hazard.
    idle();
    hif.IDRs = 5'd3; hif.IDUseRs = 1'b1; hif.IDTuseRs = T0;
    hif.EXRegDst = 5'd3; hif.EXTnew = T2; hif.ExcFlush = 1'b1;
    step("flush_data", 1'b0, 1'b0, 1'b0);

    // mult then mflo from a clean reset.
    do_reset();
    hif.EXMdStart = 1'b1; hif.EXMdIsDiv = 1'b0; hif.IDMdOp = 1'b1;
    step("mult_start", 1'b1, 1'b0, 1'b0);
    hif.EXMdStart = 1'b0;
    for (int i = 1; i <= 5; i++) step($sformatf("mult_c%0d", i), 1'b1, 1'b1, (i == 5));
    step("mflo_go", 1'b0, 1'b0, 1'b0);
    cmp("mult_total_stalls", hif.StallCnt, 32'd6);

    // div with flush in the start cycle is dropped.
    idle();
    hif.EXMdStart = 1'b1; hif.EXMdIsDiv = 1'b1; hif.IDMdOp = 1'b1; hif.ExcFlush = 1'b1;
    step("div_flush", 1'b0, 1'b0, 1'b0);
    idle();
    step("div_flush_after", 1'b0, 1'b0, 1'b0);

    // div without flush: 10 busy cycles.
    hif.EXMdStart = 1'b1; hif.EXMdIsDiv = 1'b1;
    step("div_start", 1'b0, 1'b0, 1'b0);
    idle();
    for (int i = 1; i <= 10; i++) step($sformatf("div_c%0d", i), 1'b0, 1'b1, (i == 10));
    step("div_idle", 1'b0, 1'b0, 1'b0);

    // Async reset in the middle of a div.
    hif.EXMdStart = 1'b1; hif.EXMdIsDiv = 1'b1; hif.IDMdOp = 1'b1;
    step("rdiv_start", 1'b1, 1'b0, 1'b0);
    hif.EXMdStart = 1'b0;
    step("rdiv_c1", 1'b1, 1'b1, 1'b0);
    step("rdiv_c2", 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    exp_cnt = 32'd0;
    push("rdiv_async", 1'b0, 1'b0, 1'b0);
    #2;
    pop_check();
    step("rdiv_hold", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step("rdiv_after", 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
